// File: rtl/shift_rows_seq_pkg.sv
// Shared AES ShiftRows sequencer definitions: widths, FSM encoding and
// column-major row extract/insert helpers.
package shift_rows_seq_pkg;

    localparam int unsigned AES_STATE_W = 128;
    localparam int unsigned AES_ROW_W   = 32;
    localparam int unsigned AES_NROWS   = 4;
    localparam int unsigned AES_BYTE_W  = 8;

    typedef logic [AES_STATE_W-1:0] aes_state_t;
    typedef logic [AES_ROW_W-1:0]   aes_row_t;

    typedef enum logic [1:0] {
        SR_IDLE  = 2'd0,
        SR_SHIFT = 2'd1,
        SR_DONE  = 2'd2
    } sr_state_e;

    // Gather row r as {s[r][0], s[r][1], s[r][2], s[r][3]}.
    function automatic aes_row_t get_row(input aes_state_t s, input logic [1:0] r);
        aes_row_t w;
        w = '0;
        for (int c = 0; c < int'(AES_NROWS); c++) begin
            w[5'(31 - 8*c) -: AES_BYTE_W] = s[7'(127 - 8*(4*c + int'(r))) -: AES_BYTE_W];
        end
        return w;
    endfunction

    // Scatter a row word back into row r of the state.
    function automatic aes_state_t set_row(input aes_state_t s, input logic [1:0] r,
                                           input aes_row_t w);
        aes_state_t o;
        o = s;
        for (int c = 0; c < int'(AES_NROWS); c++) begin
            o[7'(127 - 8*(4*c + int'(r))) -: AES_BYTE_W] = w[5'(31 - 8*c) -: AES_BYTE_W];
        end
        return o;
    endfunction

endpackage

// File: rtl/shift_rows_seq_row.sv
// ShiftRows row unit: left byte-rotate of one 32-bit row word by idx_row.
module shift_rows_seq_row
    import shift_rows_seq_pkg::*;
(
    input  logic [AES_ROW_W-1:0] row_in,
    input  logic [1:0]           idx_row,
    output logic [AES_ROW_W-1:0] row_out_c
);

    // Rotate so that byte (c + idx_row) % 4 lands in column c.
    always_comb begin
        row_out_c = row_in;
        case (idx_row)
            2'd0:    row_out_c = row_in;
            2'd1:    row_out_c = {row_in[23:0], row_in[31:24]};
            2'd2:    row_out_c = {row_in[15:0], row_in[31:16]};
            default: row_out_c = {row_in[7:0],  row_in[31:8]};
        endcase
    end

endmodule

// File: rtl/shift_rows_seq.sv
// AES ShiftRows sequencer: one row per clock through a shared row unit.
// Optional macro SHIFT_ROWS_INV_EN adds an 'inv' port selecting InvShiftRows.
module shift_rows_seq
    import shift_rows_seq_pkg::*;
#(
    parameter bit SKIP_ROW0 = 1'b0
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state,
    output logic                   busy,
    output logic [1:0]             row_idx
`ifdef SHIFT_ROWS_INV_EN
    ,
    input  logic                   inv
`endif
);

    localparam logic [1:0] FIRST_ROW = SKIP_ROW0 ? 2'd1 : 2'd0;

    sr_state_e  state_q, state_d;
    aes_state_t work_q, work_d;
    logic [1:0] row_cnt_q, row_cnt_d;
    logic       out_valid_q, out_valid_d;
    logic       busy_q, busy_d;
    logic [1:0] row_idx_q, row_idx_d;
    logic       accept;
    aes_row_t   row_word;
    aes_row_t   row_res;
    logic [1:0] unit_idx;
`ifdef SHIFT_ROWS_INV_EN
    logic       inv_q, inv_d;
`endif

    // Select the active row and the rotate amount for the shared row unit.
    always_comb begin
        row_word = get_row(work_q, row_cnt_q);
        unit_idx = row_cnt_q;
`ifdef SHIFT_ROWS_INV_EN
        if (inv_q) begin
            unit_idx = 2'd0 - row_cnt_q;
        end
`endif
    end

    shift_rows_seq_row u_row (
        .row_in    (row_word),
        .idx_row   (unit_idx),
        .row_out_c (row_res)
    );

    // Next-state and work-register update.
    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        row_cnt_d = row_cnt_q;
`ifdef SHIFT_ROWS_INV_EN
        inv_d     = inv_q;
`endif
        case (state_q)
            SR_IDLE, SR_DONE: begin
                if (accept) begin
                    state_d   = SR_SHIFT;
                    work_d    = in_state;
                    row_cnt_d = FIRST_ROW;
`ifdef SHIFT_ROWS_INV_EN
                    inv_d     = inv;
`endif
                end else if (state_q == SR_DONE && out_ready) begin
                    state_d = SR_IDLE;
                end
            end
            SR_SHIFT: begin
                work_d    = set_row(work_q, row_cnt_q, row_res);
                row_cnt_d = row_cnt_q + 2'd1;
                if (row_cnt_q == 2'd3) begin
                    state_d = SR_DONE;
                end
            end
            default: begin
                state_d   = SR_IDLE;
                row_cnt_d = 2'd0;
            end
        endcase
    end

    // Handshake and next values of the registered status outputs.
    always_comb begin
        in_ready    = (state_q == SR_IDLE) || ((state_q == SR_DONE) && out_ready);
        accept      = in_valid && in_ready;
        out_valid_d = (state_d == SR_DONE);
        busy_d      = (state_d != SR_IDLE);
        row_idx_d   = (state_d == SR_SHIFT) ? row_cnt_d : 2'd0;
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SR_IDLE;
            work_q      <= '0;
            row_cnt_q   <= 2'd0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            row_idx_q   <= 2'd0;
`ifdef SHIFT_ROWS_INV_EN
            inv_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            row_cnt_q   <= row_cnt_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            row_idx_q   <= row_idx_d;
`ifdef SHIFT_ROWS_INV_EN
            inv_q       <= inv_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_state = work_q;
    assign busy      = busy_q;
    assign row_idx   = row_idx_q;

endmodule

// File: tb/tb_shift_rows_seq.sv
// Self-checking bench for shift_rows_seq (default and SKIP_ROW0 instances).
// Exercises the inverse mode when SHIFT_ROWS_INV_EN is defined.
module tb_shift_rows_seq;

    logic         clk;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] in_state, out_state;
    logic [1:0]   row_idx;
    logic         inv;

    logic         sk_in_valid, sk_in_ready, sk_out_valid, sk_out_ready, sk_busy;
    logic [127:0] sk_in_state, sk_out_state;
    logic [1:0]   sk_row_idx;
    logic         sk_inv;

    int checks = 0;
    int errors = 0;
    logic [127:0] sb[$];

    typedef struct {
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    shift_rows_seq #(.SKIP_ROW0(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
        .busy(busy), .row_idx(row_idx)
`ifdef SHIFT_ROWS_INV_EN
        , .inv(inv)
`endif
    );

    shift_rows_seq #(.SKIP_ROW0(1'b1)) dut_skip (
        .clk(clk), .rst_n(rst_n),
        .in_valid(sk_in_valid), .in_ready(sk_in_ready), .in_state(sk_in_state),
        .out_valid(sk_out_valid), .out_ready(sk_out_ready), .out_state(sk_out_state),
        .busy(sk_busy), .row_idx(sk_row_idx)
`ifdef SHIFT_ROWS_INV_EN
        , .inv(sk_inv)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    function automatic logic [127:0] sr_model(input logic [127:0] s, input bit inv_m);
        logic [7:0]   b [4][4];
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                b[r][c] = s[7'(127 - 8*(4*c + r)) -: 8];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[7'(127 - 8*(4*c + r)) -: 8] = inv_m ? b[r][(c + 4 - r) % 4] : b[r][(c + r) % 4];
        return o;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: compare on every output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got %h expected none", out_state);
            end else begin
                chk("sb_out", out_state, sb.pop_front());
            end
        end
    end

    // Send one state, push its expectation, measure accept-to-out_valid latency.
    task automatic xfer(input logic [127:0] s, input logic [127:0] exp,
                        input int exp_lat, input bit toggle);
        int n;
        n = 0;
        in_state = s;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 128'(in_ready), 128'(1));
            in_valid = 1'b0;
            return;
        end
        sb.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            if (toggle) in_state = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(posedge clk); #1; n++;
        end
        chk("latency", 128'(n), 128'(exp_lat));
        n = 0;
        while (out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic sk_xfer(input logic [127:0] s, input logic [127:0] exp);
        int n;
        n = 0;
        sk_in_state = s;
        sk_in_valid = 1'b1;
        chk("sk_in_ready", 128'(sk_in_ready), 128'(1));
        @(posedge clk); #1;
        sk_in_valid = 1'b0;
        while (!sk_out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("sk_latency", 128'(n), 128'(3));
        chk("sk_out", sk_out_state, exp);
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t         tbl [8];
        logic [127:0] a, b, r;
        int           n;

        tbl[0] = '{128'hd42711aee0bf98f1b8b45de51e415230, 128'hd4bf5d30e0b452aeb84111f11e2798e5};
        tbl[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00050a0f04090e03080d02070c01060b};
        tbl[2] = '{128'h0, 128'h0};
        tbl[3] = '{{128{1'b1}}, {128{1'b1}}};
        for (int i = 4; i < 8; i++) begin
            a = {$urandom(), $urandom(), $urandom(), $urandom()};
            tbl[i] = '{a, sr_model(a, 1'b0)};
        end

        in_valid = 0; in_state = '0; out_ready = 1; inv = 0;
        sk_in_valid = 0; sk_in_state = '0; sk_out_ready = 1; sk_inv = 0;
        rst_n = 1;
        #1 rst_n = 0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1;
        @(posedge clk); #1;

        // Reset state
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_state", out_state, 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_row_idx", 128'(row_idx), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));

        // Table vectors, with in_state scrambled during SHIFT on odd entries
        for (int i = 0; i < 8; i++) begin
            xfer(tbl[i].din, tbl[i].exp, 4, (i % 2) == 1);
        end

        // SKIP_ROW0 instance: same results, one cycle shorter
        sk_xfer(tbl[1].din, tbl[1].exp);
        sk_xfer(tbl[0].din, tbl[0].exp);

        // Backpressure in DONE with the next state waiting
        a = tbl[0].din;
        b = tbl[1].din;
        out_ready = 1'b0;
        in_state = a; in_valid = 1'b1;
        sb.push_back(sr_model(a, 1'b0));
        @(posedge clk); #1;
        in_state = b;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", 128'(out_valid), 128'(1));
            chk("bp_out_state", out_state, tbl[0].exp);
            chk("bp_in_ready", 128'(in_ready), 128'(0));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 128'(in_ready), 128'(1));
        sb.push_back(sr_model(b, 1'b0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_next_busy", 128'(busy), 128'(1));
        chk("bp_next_out_valid", 128'(out_valid), 128'(0));
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 30) begin
            @(posedge clk); #1; n++;
        end
        chk("bp_drain", 128'(sb.size()), 128'(0));

        // Reset while row 2 is in the row unit
        in_state = tbl[5].din; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("mid_row_idx", 128'(row_idx), 128'(2));
        chk("mid_busy", 128'(busy), 128'(1));
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_out_state", out_state, 128'(0));
        chk("mid_rst_busy", 128'(busy), 128'(0));
        chk("mid_rst_row_idx", 128'(row_idx), 128'(0));
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 128'(in_ready), 128'(1));
        xfer(tbl[6].din, tbl[6].exp, 4, 1'b0);

`ifdef SHIFT_ROWS_INV_EN
        // Inverse mode: FIPS vector backwards, then random round trip
        inv = 1'b1;
        xfer(128'hd4bf5d30e0b452aeb84111f11e2798e5, 128'hd42711aee0bf98f1b8b45de51e415230, 4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            r = {$urandom(), $urandom(), $urandom(), $urandom()};
            inv = 1'b0;
            xfer(r, sr_model(r, 1'b0), 4, 1'b0);
            inv = 1'b1;
            xfer(sr_model(r, 1'b0), r, 4, 1'b1);
        end
        sk_inv = 1'b1;
        sk_xfer(128'hd4bf5d30e0b452aeb84111f11e2798e5, 128'hd42711aee0bf98f1b8b45de51e415230);
        sk_inv = 1'b0;
        inv = 1'b0;
`endif

        chk("final_sb_empty", 128'(sb.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
